// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder: one operand pair per handshake,
// stepping compare/swap, serial alignment, add/sub and serial normalization.
module fp_add_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, DONE} state_t;

   state_t      state, state_next;

   logic [31:0] a_q, b_q;
   logic        sign, sub;
   logic [7:0]  exp_q, diff;
   logic [23:0] man_a, man_b;
   logic [24:0] sum;

   // Compare/swap view of the latched operands.
   logic [7:0]  ea, eb, cmp_diff;
   logic [23:0] ma, mb;
   logic        swap, special;

   always_comb begin
      ea       = a_q[30:23];
      eb       = b_q[30:23];
      ma       = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
      mb       = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
      swap     = {eb, mb} > {ea, ma};
      special  = (ea == 8'hFF) || (eb == 8'hFF);
      cmp_diff = swap ? (eb - ea) : (ea - eb);
   end

   // A shift that lands on a normalized (or underflowing) value finishes in
   // the same cycle, so NORM occupies max(shifts, 1) cycles.
   logic [7:0]  exp_inc, exp_dec;
   logic        norm_done;
   logic [31:0] norm_res;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      exp_inc   = exp_q + 8'd1;
      exp_dec   = exp_q - 8'd1;
      norm_done = 1'b1;
      norm_res  = 32'h0000_0000;
      if (sum == 25'd0)
         norm_res = 32'h0000_0000;
      else if (sum[24])
         norm_res = (exp_inc == 8'hFF) ? {sign, 8'hFF, 23'h0} : {sign, exp_inc, sum[23:1]};
      else if (sum[23])
         norm_res = {sign, exp_q, sum[22:0]};
      else if (exp_q == 8'd1)
         norm_res = {sign, 31'h0};
      else if (sum[22])
         norm_res = {sign, exp_dec, sum[21:0], 1'b0};
      else if (exp_dec == 8'd1)
         norm_res = {sign, 31'h0};
      else
         norm_done = 1'b0;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = CMP;
         CMP: begin
            if (special)                state_next = DONE;
            else if (cmp_diff == 8'd0)  state_next = ADD;
            else                        state_next = ALIGN;
         end
         ALIGN:   if (diff >= 8'd24 || diff == 8'd1) state_next = ADD;
         ADD:     state_next = NORM;
         NORM:    if (norm_done) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: registers are updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         sign   <= 1'b0;
         sub    <= 1'b0;
         exp_q  <= '0;
         diff   <= '0;
         man_a  <= '0;
         man_b  <= '0;
         sum    <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q <= a;
                  b_q <= b;
               end
            end
            CMP: begin
               if (special) result <= 32'h7FC0_0000;
               sign  <= swap ? b_q[31] : a_q[31];
               sub   <= a_q[31] ^ b_q[31];
               exp_q <= swap ? eb : ea;
               diff  <= cmp_diff;
               man_a <= swap ? mb : ma;
               man_b <= swap ? ma : mb;
            end
            ALIGN: begin
               // Truncating alignment: bits shifted past the LSB are dropped.
               if (diff >= 8'd24) begin
                  man_b <= '0;
                  diff  <= '0;
               end else begin
                  man_b <= man_b >> 1;
                  diff  <= diff - 8'd1;
               end
            end
            ADD: begin
               sum <= sub ? ({1'b0, man_a} - {1'b0, man_b})
                          : ({1'b0, man_a} + {1'b0, man_b});
            end
            NORM: begin
               if (norm_done) begin
                  result <= norm_res;
               end else begin
                  sum   <= {sum[23:0], 1'b0};
                  exp_q <= exp_dec;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed vector table, handshake and
// reset corner sequences, and random operands against an arithmetic model.
module tb_fp_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   fp_add_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic following the adder's rules.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output int lat);
      int     ex, ey, d, e, n, al, ti;
      longint mx, my, s, kx, ky, tl;
      logic   sx, sy, tb;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      if (ex == 255 || ey == 255) begin
         r   = 32'h7FC0_0000;
         lat = 2;
         return;
      end
      mx = (ex == 0) ? 0 : longint'(x[22:0]) + 64'd8388608;
      my = (ey == 0) ? 0 : longint'(y[22:0]) + 64'd8388608;
      sx = x[31];
      sy = y[31];
      kx = longint'(ex) * 16777216 + mx;
      ky = longint'(ey) * 16777216 + my;
      if (ky > kx) begin
         ti = ex; ex = ey; ey = ti;
         tl = mx; mx = my; my = tl;
         tb = sx; sx = sy; sy = tb;
      end
      d = ex - ey;
      if (d >= 24) begin
         my = 0;
         al = 1;
      end else begin
         my = my >> d;
         al = d;
      end
      s = (sx == sy) ? mx + my : mx - my;
      e = ex;
      n = 0;
      if (s == 0) begin
         r = 32'h0000_0000;
      end else if (s >= 64'd16777216) begin
         s = s / 2;
         e = e + 1;
         n = 1;
         r = (e == 255) ? {sx, 8'hFF, 23'h0} : {sx, e[7:0], s[22:0]};
      end else begin
         while (s < 64'd8388608 && e > 1) begin
            s = s * 2;
            e = e - 1;
            n = n + 1;
         end
         r = (s < 64'd8388608) ? {sx, 31'h0} : {sx, e[7:0], s[22:0]};
      end
      lat = 3 + al + ((n > 1) ? n : 1);
   endfunction

   // One full transaction; latency counts the accept cycle as 0.
   task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                         output logic [31:0] res, output int lat);
      @(negedge clk);
      a        = xa;
      b        = xb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = result;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t        vecs [10];
      logic [31:0] res, exp_res;
      int          lat, exp_lat, guard;

      vecs[0] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4020_0000, 4};
      vecs[1] = '{32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 5};
      vecs[2] = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 5};
      vecs[3] = '{32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000, 4};
      vecs[4] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 4};
      vecs[5] = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 4};
      vecs[6] = '{32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 2};
      vecs[7] = '{32'h8120_0000, 32'h0100_0000, 32'h8000_0000, 4};
      vecs[8] = '{32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 5};
      vecs[9] = '{32'hC040_0000, 32'h3F80_0000, 32'hC000_0000, 5};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #12;
      check("rst_in_ready",  {31'b0, in_ready},  32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result",    result,             32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, res, lat);
         check($sformatf("vec%0d_result", i), res, vecs[i].res);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Back-pressure: result held, new request blocked while DONE.
      @(negedge clk);
      a        = 32'h4000_0000;
      b        = 32'h3F80_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      guard    = 0;
      while (!out_valid && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("bp_result", result, 32'h4040_0000);
      @(negedge clk);
      in_valid = 1'b1;
      a        = 32'h3F80_0000;
      b        = 32'h3F80_0000;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", {31'b0, out_valid}, 32'd1);
         check("bp_hold",      result,             32'h4040_0000);
         check("bp_in_ready",  {31'b0, in_ready},  32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("bp_release_valid", {31'b0, out_valid}, 32'd0);
      check("bp_release_ready", {31'b0, in_ready},  32'd1);
      @(posedge clk);
      #1;
      check("bp_single_xfer", {31'b0, out_valid}, 32'd0);

      // Reset during alignment aborts the operation immediately.
      @(negedge clk);
      a        = 32'h4B00_0000;
      b        = 32'h3F80_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check("abort_busy", {31'b0, in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      check("abort_in_ready",  {31'b0, in_ready},  32'd1);
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(32'h3F80_0000, 32'h3F80_0000, res, lat);
      check("post_abort_result",  res,      32'h4000_0000);
      check("post_abort_latency", 32'(lat), 32'd4);

      // Random operands against the model.
      for (int i = 0; i < 200; i++) begin
         int          ea, eb, sel;
         logic [31:0] fa, fb;
         logic        sa, sb;
         logic [31:0] xa, xb;
         ea  = $urandom_range(1, 254);
         eb  = ea + int'($urandom_range(0, 50)) - 25;
         if (eb < 0)   eb = 0;
         if (eb > 254) eb = 254;
         sel = $urandom_range(0, 31);
         fa  = $urandom;
         fb  = $urandom;
         sa  = fa[31];
         sb  = fb[31];
         if (sel == 0) eb = 255;
         if (sel == 1) eb = 0;
         if (sel >= 2 && sel <= 9) begin
            eb = ea;
            fb = fa ^ ($urandom & 32'h0000_00FF);
            sb = ~sa;
         end
         xa = {sa, ea[7:0], fa[22:0]};
         xb = {sb, eb[7:0], fb[22:0]};
         model(xa, xb, exp_res, exp_lat);
         run_op(xa, xb, res, lat);
         check($sformatf("rnd%0d_result(%h+%h)", i, xa, xb), res, exp_res);
         check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_add_seq.md
# fp_add_seq

Multi-cycle IEEE-754 single-precision adder controller: it accepts one operand pair over a valid/ready handshake and steps the add datapath through its stages. The stages are compare/swap, iterative alignment shift, 25-bit mantissa add/subtract and iterative normalization (Norm semantics: carry bit 24 → one right shift, else left shift until bit 23 set). It then holds the packed result until the consumer takes it. It sits between the operand source and the FP result sink, replacing the purely combinational align/Norm path with one shifter step per cycle.

## Interface
- Parameters: none.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- result  output  32  sum a+b, IEEE-754 single.

## Operation
- States: IDLE, CMP, ALIGN, ADD, NORM, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b → CMP.
- CMP (1 cycle): exponent field 0 → operand treated as ±0, mantissa 0. Either exponent field 255 → result=32'h7FC0_0000, go directly to DONE. Otherwise form 24-bit mantissas with hidden 1 and swap so A has the larger magnitude (exp, then mantissa). diff=expA−expB. diff=0 → ADD, else → ALIGN.
- ALIGN: diff≥24 → clear mantissa B in one cycle → ADD. Otherwise shift mantissa B right 1 bit per cycle and decrement diff; → ADD when diff reaches 0. Shifted-out bits are discarded (truncation, no guard/round/sticky).
- ADD (1 cycle): equal signs → sum=mA+mB; else sum=mA−mB (never negative). sum is 25 bits. Result sign = sign of A. exp=expA.
- NORM, one action per cycle:
  - sum==0 → result=32'h0000_0000 (+0) → DONE.
  - sum[24]=1 → sum>>1, exp+1; if exp becomes 255 → result={sign,8'hFF,23'h0} → DONE.
  - sum[23]=1 → pack {sign, exp, sum[22:0]} → DONE.
  - Else, if exp==1 → result=±0 (flush underflow) → DONE; else sum<<1, exp−1 and stay.
- DONE: out_valid=1, result stable. On out_ready → IDLE. out_valid&&out_ready and a new in_valid in the same cycle: new operands are not accepted until the next cycle (in_ready is 0 in DONE).
- No denormal outputs, no rounding beyond truncation, one operation in flight.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, all internal registers 0. Reset asserted mid-operation aborts it; the operation is lost and no out_valid is produced.
- Let A = alignment cycles (0 if diff=0; diff if 1≤diff≤23; 1 if diff≥24). Let N = NORM shift cycles (right or left shifts).
- Latency: out_valid rises 3+A+max(N,1) cycles after the accept edge. NaN/Inf input path: 2 cycles.
- Throughput: next accept no earlier than one cycle after the out_valid&&out_ready edge.
- out_valid stays high and result is unchanged while out_ready=0 (unbounded back-pressure).
- Inputs a/b are sampled only at the accept edge; later changes have no effect.

## Test plan
- 3F80_0000 + 3FC0_0000 (1.0+1.5), out_ready=1 → result 4020_0000. Carry path, N=1, out_valid 4 cycles after accept.
- 4000_0000 + 3F80_0000 (2.0+1.0) → 4040_0000, A=1, latency 5. Then 3F80_0000 + 3380_0000 (diff 24) → 3F80_0000, latency 5.
- 3FC0_0000 + BF80_0000 (1.5−1.0) → 3F00_0000, one left shift. Then 3F80_0000 + BF80_0000 → 0000_0000, latency 4.
- 7F7F_FFFF + 7F7F_FFFF → 7F80_0000 (overflow to +Inf). 7F80_0000 + 3F80_0000 → 7FC0_0000, latency 2.
- Hold out_ready=0 for 10 cycles after out_valid → result and out_valid stable, in_ready=0 with in_valid held high. Release → exactly one transfer, in_ready=1 next cycle.
- Assert rst while in ALIGN on 4B00_0000 + 3F80_0000 → out_valid=0 and in_ready=1 immediately (async). The next operation 3F80_0000 + 3F80_0000 returns 4000_0000.
